// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } sched_state_t;

  localparam logic [7:0] BCAST_ID_DEF = 8'hFF;

  // Widest packet the header helper accepts; narrower packets are zero-extended.
  localparam int PKT_MAX_W = 256;

  // Destination ID lives in the top byte of the packet.
  function automatic logic [7:0] dest_of(input logic [PKT_MAX_W-1:0] pkt, input int sz);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (sz - 8);
    return sh[7:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request searching upward from last+1, wrapping.
module rr_arbiter #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]         req,
  input  logic [$clog2(drvrs)-1:0] last,
  output logic [$clog2(drvrs)-1:0] gnt,
  output logic                     gnt_vld
);

  localparam int IDW = $clog2(drvrs);

  logic [IDW-1:0] idx;

  // Scan every device once, starting just after the previous winner.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= drvrs; i++) begin
      idx = IDW'((int'(last) + i) % drvrs);
      if (!gnt_vld && req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin bus scheduler: pops one packet from the granted device FIFO and
// pushes it to the destination FIFO named in its header.
// Optional feature macro: BUS_SCHED_BCAST_EN enables broadcast delivery of
// BCAST_ID packets; without it such packets are dropped and counted.
module bus_rr_scheduler
  import bus_sched_pkg::*;
#(
  parameter int         pckg_sz  = 16,
  parameter int         drvrs    = 4,
  parameter logic [7:0] BCAST_ID = BCAST_ID_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic                            busy,
  output logic [$clog2(drvrs)-1:0]        grant_id,
  output logic [15:0]                     drop_cnt
);

  localparam int IDW = $clog2(drvrs);

  sched_state_t       state, state_nxt;
  logic [drvrs-1:0]   pop_nxt, push_nxt;
  logic [pckg_sz-1:0] pkt_nxt;
  logic               busy_nxt;
  logic [IDW-1:0]     grant_nxt;
  logic [15:0]        drop_nxt;

  logic [IDW-1:0]     arb_gnt;
  logic               arb_vld;
  logic [pckg_sz-1:0] head;
  logic [7:0]         dest;
  logic               bcast_hit;
  logic               unicast_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rr_arbiter #(.drvrs(drvrs)) u_arb (
    .req     (pndng),
    .last    (grant_id),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  // Head word of the granted FIFO is stable while it is pending (show-ahead).
  assign head = D_pop[grant_id];
  assign dest = dest_of(PKT_MAX_W'(head), pckg_sz);

`ifdef BUS_SCHED_BCAST_EN
  assign bcast_hit = (dest == BCAST_ID);
`else
  assign bcast_hit = 1'b0;
`endif

  // BCAST_ID never addresses a single device; a packet to its own source is dropped.
  assign unicast_ok = (int'(dest) < drvrs) && (dest != 8'(grant_id)) && (dest != BCAST_ID);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt = state;
    pop_nxt   = '0;
    push_nxt  = '0;
    busy_nxt  = 1'b0;
    grant_nxt = grant_id;
    pkt_nxt   = D_push;
    drop_nxt  = drop_cnt;
    case (state)
      IDLE: begin
        if (arb_vld) begin
          grant_nxt        = arb_gnt;
          pop_nxt[arb_gnt] = 1'b1;
          busy_nxt         = 1'b1;
          state_nxt        = POP;
        end
      end
      POP: begin
        pkt_nxt   = head;
        busy_nxt  = 1'b1;
        state_nxt = PUSH;
        if (bcast_hit) begin
          push_nxt           = '1;
          push_nxt[grant_id] = 1'b0;
        end else if (unicast_ok) begin
          push_nxt[dest[IDW-1:0]] = 1'b1;
        end else begin
          drop_nxt = sat_inc(drop_cnt);
        end
      end
      PUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      grant_id <= IDW'(drvrs - 1);
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pop      <= pop_nxt;
      push     <= push_nxt;
      D_push   <= pkt_nxt;
      busy     <= busy_nxt;
      grant_id <= grant_nxt;
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: device FIFOs modelled as queues, a
// transaction-level round-robin model predicts every pop/push/drop.
module tb_bus_rr_scheduler;

`ifdef BUS_SCHED_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       pndng;
  logic [3:0][15:0] D_pop;
  logic [3:0]       pop;
  logic [3:0]       push;
  logic [15:0]      D_push;
  logic             busy;
  logic [1:0]       grant_id;
  logic [15:0]      drop_cnt;

  typedef struct {
    int          src;
    logic [3:0]  mask;
    logic [15:0] data;
    int          drop_after;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] src_q[4][$];
  int          m_last;
  int          m_drop;
  int          n_chk;
  int          n_fail;
  bit          mon_en;
  bit          in_push;
  bit          chk_spacing;
  int          cyc;
  int          last_pop_cyc;
  exp_t        cur;
  logic [3:0]  pop_s;

  bus_rr_scheduler #(.pckg_sz(16), .drvrs(4), .BCAST_ID(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Device FIFOs: pop takes effect at the edge that ends the pop cycle.
  initial begin
    pndng = '0;
    D_pop = '0;
    forever begin
      @(negedge clk);
      pop_s = pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (pop_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      for (int i = 0; i < 4; i++) begin
        pndng[i] = (src_q[i].size() > 0);
        D_pop[i] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0000;
      end
    end
  end

  // Monitor: each pop is matched to the next expected transaction, the push
  // (or drop) is checked in the following cycle.
  initial begin
    cyc = 0;
    in_push = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        in_push = 1'b0;
      end else begin
        check("pop_push_excl", 32'(|pop && |push), 32'h0);
        if (in_push) begin
          check("push_mask", 32'(push), 32'(cur.mask));
          if (cur.mask != 4'h0) check("push_data", 32'(D_push), 32'(cur.data));
          check("drop_cnt", 32'(drop_cnt), cur.drop_after);
          check("busy_push", 32'(busy), 32'h1);
          in_push = 1'b0;
        end else if (|push) begin
          check("stray_push", 32'(push), 32'h0);
        end
        if (|pop) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pop", 32'(pop), 32'h0);
          end else begin
            cur = exp_q.pop_front();
            check("pop_src", 32'(pop), 32'(4'b0001 << cur.src));
            check("grant_id", 32'(grant_id), cur.src);
            check("busy_pop", 32'(busy), 32'h1);
            if (chk_spacing && last_pop_cyc >= 0) check("grant_spacing", cyc - last_pop_cyc, 32'd3);
            last_pop_cyc = cyc;
            in_push = 1'b1;
          end
        end
      end
    end
  end

  // Reference model: drain every loaded queue in round-robin order.
  task automatic predict();
    int   rd[4];
    int   s;
    int   c;
    int   d;
    exp_t e;
    for (int i = 0; i < 4; i++) rd[i] = 0;
    while (1) begin
      s = -1;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (s < 0 && rd[c] < src_q[c].size()) s = c;
      end
      if (s < 0) break;
      e.data = src_q[s][rd[s]];
      rd[s]++;
      m_last = s;
      d = {24'd0, e.data[15:8]};
      e.src = s;
      e.mask = 4'h0;
      if (BCAST_EN && d == 255) e.mask = 4'hF & ~(4'b0001 << s);
      else if (d < 4 && d != s) e.mask = 4'b0001 << d;
      else if (m_drop < 65535) m_drop++;
      e.drop_after = m_drop;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() > 0 || in_push) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);
    check({name, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_last = 3;
    m_drop = 0;
  endtask

  function automatic logic [7:0] rand_hdr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 8'($urandom_range(0, 3));
    if (r < 8) return 8'($urandom_range(4, 254));
    return 8'hFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    mon_en = 1'b0;
    chk_spacing = 1'b0;
    last_pop_cyc = -1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pop", 32'(pop), 32'h0);
    check("rst_push", 32'(push), 32'h0);
    check("rst_dpush", 32'(D_push), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h3);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    reset = 1'b0;
    m_last = 3;
    m_drop = 0;
    mon_en = 1'b1;

    // Single packet with exact latency.
    @(negedge clk);
    src_q[1].push_back(16'h02AB);
    predict();
    @(negedge clk);
    check("sp_pop_early", 32'(pop), 32'h0);
    @(negedge clk);
    check("sp_pop", 32'(pop), 32'h2);
    @(negedge clk);
    check("sp_push", 32'(push), 32'h4);
    check("sp_dpush", 32'(D_push), 32'h02AB);
    check("sp_drop", 32'(drop_cnt), 32'h0);
    drain("single");

    // Round-robin with all sources pending.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      repeat (2) src_q[i].push_back({8'((i + 1) % 4), 8'($urandom)});
    chk_spacing = 1'b1;
    last_pop_cyc = -1;
    predict();
    check("rr_first_src", 32'(exp_q[0].src), 32'h0);
    drain("rr");
    chk_spacing = 1'b0;

    // Broadcast header.
    do_reset();
    @(negedge clk);
    src_q[2].push_back(16'hFF55);
    predict();
    drain("bcast");
    check("bcast_drop", 32'(drop_cnt), BCAST_EN ? 32'h0 : 32'h1);

    // Out-of-range destination, then a packet addressed to its own source.
    do_reset();
    @(negedge clk);
    src_q[0].push_back(16'h0711);
    src_q[0].push_back(16'h0022);
    predict();
    drain("invalid");
    check("invalid_drop", 32'(drop_cnt), 32'h2);

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        int n;
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) src_q[i].push_back({rand_hdr(), 8'($urandom)});
      end
      predict();
      drain("random");
    end

    // Reset asserted during the pop cycle.
    mon_en = 1'b0;
    @(negedge clk);
    src_q[1].push_back(16'h02AB);
    for (int t = 0; t < 10 && !(|pop); t++) @(negedge clk);
    check("mid_pop", 32'(pop), 32'h2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_push", 32'(push), 32'h0);
    check("mid_pop_low", 32'(pop), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_grant", 32'(grant_id), 32'h3);
    check("mid_drop", 32'(drop_cnt), 32'h0);
    m_last = 3;
    m_drop = 0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    src_q[3].push_back(16'h0122);
    predict();
    drain("post_reset");

    // Drop counter saturation.
    @(negedge clk);
    force dut.drop_cnt = 16'hFFFD;
    #1;
    release dut.drop_cnt;
    m_drop = 65533;
    @(negedge clk);
    repeat (5) src_q[0].push_back({8'h07, 8'($urandom)});
    predict();
    drain("saturate");
    check("sat_value", 32'(drop_cnt), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_scheduler.md
# bus_rr_scheduler

Round-robin scheduler that sequences the shared packet bus between `drvrs` device FIFOs. It watches each FIFO's `pndng` flag and pops one packet at a time from the granted source. It decodes the destination ID from the packet header and pushes the packet into the destination FIFO, or into all FIFOs on broadcast. It sits between the per-device FIFOs and the bus fabric, and is the control element the bus-driver environment exercises through its `pndng`/`pop`/`push`/`D_pop`/`D_push` interface.

## Interface
- `pckg_sz`, 16: packet width in bits; header ID is `pckg_sz-1 -: 8`.
- `drvrs`, 4: number of attached devices (2..255).
- `BCAST_ID`, 8'hFF: header ID meaning "all devices".
- `clk`  in  1  — single clock; everything is rising-edge.
- `reset`  in  1  — synchronous, active-high.
- `pndng`  in  drvrs  — bit i high: FIFO i non-empty, head word valid on `D_pop[i]` (show-ahead).
- `D_pop`  in  drvrs×pckg_sz  — packed array, head word of each FIFO.
- `pop`  out  drvrs  — one-hot pop strobe.
- `push`  out  drvrs  — push strobe; one-hot, or multi-hot on broadcast.
- `D_push`  out  pckg_sz  — packet shared by all destinations.
- `busy`  out  1  — high in POP and PUSH states.
- `grant_id`  out  $clog2(drvrs)  — last granted source.
- `drop_cnt`  out  16  — count of dropped packets, saturating.

## Operation
- States: IDLE, POP, PUSH. All outputs registered.
- IDLE: if any `pndng`, pick the first set bit searching upward from `grant_id+1`, wrapping modulo `drvrs`. Register it into `grant_id` and go to POP.
- IDLE with no `pndng`: stay in IDLE.
- POP:
  - `pop[grant_id]`=1 for exactly one cycle.
  - Latch `D_pop[grant_id]` into the packet register and decode the destination.
  - Go to PUSH.
- PUSH, destination valid (ID < `drvrs` and ID ≠ source): `push[ID]`=1 for one cycle, `D_push`=packet.
- PUSH, broadcast: `push` = all ones except the source bit.
- PUSH, invalid destination (ID ≥ `drvrs` and not broadcast, or ID = source): no push, `drop_cnt`+1, saturating at 16'hFFFF.
- PUSH always returns to IDLE.
- The destination FIFO's fullness is not checked; overflow protection is the FIFO's responsibility.
- Fairness: a continuously pending source waits at most `drvrs-1` packets between grants.

## Timing
- Reset values: state=IDLE, `pop`=0, `push`=0, `D_push`=0, `busy`=0, `grant_id`=`drvrs-1` (so driver 0 wins first), `drop_cnt`=0.
- Latency: `pndng` seen high at edge k → `pop` high in cycle k+1 → `push` high in cycle k+2.
- Throughput: one packet per 3 cycles.
- `pop` and `push` are never high in the same cycle.
- `pndng` dropping while in POP does not cancel the pop; the latched word is used. The FIFO must keep the head stable while `pndng` is high.
- Reset during POP or PUSH: the next cycle is IDLE with all strobes low. A popped packet in flight is lost and is not counted in `drop_cnt`.
- `reset` has priority over every transition.

## Configuration
- `BUS_SCHED_BCAST_EN` defined: broadcast behaves as described in Operation.
- `BUS_SCHED_BCAST_EN` undefined: `BCAST_ID` is treated as an invalid destination. The packet is dropped and `drop_cnt` increments.

## Structure
- Package `bus_sched_pkg`:
  - state enum `sched_state_t`
  - `BCAST_ID` default
  - function `dest_of(pkt)` that extracts the header ID.
- Sub-module `rr_arbiter`: combinational; takes `req[drvrs]` and `last[$clog2(drvrs)]`, outputs `gnt` index and `gnt_vld`. Reusable elsewhere in the bus environment.
- The top holds the FSM, packet register, push decode and drop counter.

## Test plan
- Single packet: `drvrs`=4, `pndng`=4'b0010, `D_pop[1]`=16'h02AB → `pop`=4'b0010 at k+1, `push`=4'b0100 with `D_push`=16'h02AB at k+2, `drop_cnt`=0.
- Round-robin: `pndng`=4'b1111 held, all headers valid → grant order 0,1,2,3,0, with grants spaced 3 cycles apart.
- Broadcast: `D_pop[2]`=16'hFF55 → with macro, `push`=4'b1011; without macro, no push and `drop_cnt`=1.
- Invalid destination: header 8'h07 from source 0, then header 8'h00 from source 0 → no push for either, `drop_cnt`=2.
- Reset mid-flow: assert `reset` in the POP cycle → next cycle state=IDLE, `push`=0, `grant_id`=3. Then `pndng`=4'b1000 → driver 3 is granted.
- Saturation: force `drop_cnt` near 16'hFFFF via repeated bad headers → it holds at 16'hFFFF.
